sr_bank: RTL and testbench

Parametrised bank of independent set/reset storage channels: the multi-channel successor to the single SR flip-flop. Each channel has its own enable, a selectable policy for the S=R=1 case, and registered edge pulses. A sticky per-channel conflict flag and a saturating conflict counter report S=R=1 events. The block sits between control/status logic and anything that needs latched event bits, for example interrupt-pending or error-latch registers.

---
 rtl/sr_pkg.sv | 44 ++++
 rtl/sr_cell.sv | 54 +++++
 rtl/sr_bank.sv | 81 ++++++++
 tb/tb_sr_bank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the sr_bank set/reset storage bank:
// conflict-mode encoding and the per-channel next-state rule.
`timescale 1ns/1ps
package sr_pkg;

    typedef enum logic [1:0] {
        SR_HOLD    = 2'd0,
        SR_SET_DOM = 2'd1,
        SR_RST_DOM = 2'd2,
        SR_TOGGLE  = 2'd3
    } sr_mode_e;

    // clr outranks enable; s=r=1 resolves through the configured mode.
    function automatic logic sr_next(
        input logic     q,
        input logic     en,
        input logic     s,
        input logic     r,
        input logic     clr,
        input sr_mode_e mode
    );
        logic nq;
        nq = q;
        if (clr) begin
            nq = 1'b0;
        end else if (en) begin
            case ({s, r})
                2'b01:   nq = 1'b0;
                2'b10:   nq = 1'b1;
                2'b11: begin
                    case (mode)
                        SR_HOLD:    nq = q;
                        SR_SET_DOM: nq = 1'b1;
                        SR_RST_DOM: nq = 1'b0;
                        default:    nq = ~q;
                    endcase
                end
                default: nq = q;
            endcase
        end
        return nq;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One set/reset storage channel: state bit, registered edge pulses and
// the sticky conflict flag.
`timescale 1ns/1ps
module sr_cell
    import sr_pkg::*;
#(
    parameter int CONFLICT_MODE = 0
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_s,
    input  logic i_r,
    input  logic i_clr,
    input  logic i_conflict_clr,
    output logic o_q,
    output logic o_rise,
    output logic o_fall,
    output logic o_conflict
);

    localparam sr_mode_e MODE = sr_mode_e'(2'(CONFLICT_MODE));

    logic r_q;
    logic r_rise;
    logic r_fall;
    logic r_conflict;
    logic w_next;
    logic w_evt;

    assign w_next = sr_next(r_q, i_en, i_s, i_r, i_clr, MODE);
    // Detection ignores clr so a cleared channel still reports the conflict.
    assign w_evt  = i_en & i_s & i_r;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q        <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_q        <= w_next;
            r_rise     <= ~r_q & w_next;
            r_fall     <= r_q & ~w_next;
            r_conflict <= w_evt | (r_conflict & ~i_conflict_clr);
        end
    end

    assign o_q        = r_q;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_conflict = r_conflict;

endmodule

// File: rtl/sr_bank.sv
// Bank of independent set/reset channels with a shared saturating counter
// of cycles in which any channel saw s=r=1 while enabled.
`timescale 1ns/1ps
module sr_bank
    import sr_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int CONFLICT_MODE = 0,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] s,
    input  logic [CHANNELS-1:0] r,
    input  logic                clr,
    input  logic                conflict_clr,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] q_rise,
    output logic [CHANNELS-1:0] q_fall,
    output logic [CHANNELS-1:0] conflict,
    output logic [CNT_W-1:0]    conflict_cnt
);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("sr_bank: CHANNELS must be 1..32");
    end
    if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
        $error("sr_bank: CONFLICT_MODE must be 0..3");
    end
    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
        $error("sr_bank: CNT_W must be 2..16");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0] w_q;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_conflict;
    logic                w_any;
    logic [CNT_W-1:0]    r_cnt;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cell
        sr_cell #(
            .CONFLICT_MODE(CONFLICT_MODE)
        ) u_cell (
            .clk           (clk),
            .i_rst_n       (reset),
            .i_en          (en[g]),
            .i_s           (s[g]),
            .i_r           (r[g]),
            .i_clr         (clr),
            .i_conflict_clr(conflict_clr),
            .o_q           (w_q[g]),
            .o_rise        (w_rise[g]),
            .o_fall        (w_fall[g]),
            .o_conflict    (w_conflict[g])
        );
    end

    // Simultaneous events on several channels count as a single cycle.
    assign w_any = |(en & s & r);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (conflict_clr) begin
            r_cnt <= {{(CNT_W-1){1'b0}}, w_any};
        end else if (w_any && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign q            = w_q;
    assign q_rise       = w_rise;
    assign q_fall       = w_fall;
    assign conflict     = w_conflict;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_bank.sv
// Scoreboard bench for sr_bank: four instances (modes 0..3, the mode-3 one
// with a 2-bit counter) share stimulus and are checked against a reference model.
`timescale 1ns/1ps
module tb_sr_bank;

    typedef struct packed {
        logic [3:0]  q;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  conf;
        logic [15:0] cnt;
    } obs_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] en    = '0;
    logic [3:0] s     = '0;
    logic [3:0] r     = '0;
    logic       clr   = 1'b0;
    logic       cclr  = 1'b0;

    logic [3:0]  q_o    [4];
    logic [3:0]  rise_o [4];
    logic [3:0]  fall_o [4];
    logic [3:0]  conf_o [4];
    logic [15:0] cnt_o  [4];
    obs_t        obs    [4];

    obs_t expq [4][$];

    int vectors = 0;
    int errs    = 0;

    logic [3:0] mq    [4];
    logic [3:0] mconf [4];
    int         mcnt  [4];
    int         cmax  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CW = (g == 3) ? 2 : 8;
        logic [CW-1:0] w_cnt;
        sr_bank #(
            .CHANNELS     (4),
            .CONFLICT_MODE(g),
            .CNT_W        (CW)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .en          (en),
            .s           (s),
            .r           (r),
            .clr         (clr),
            .conflict_clr(cclr),
            .q           (q_o[g]),
            .q_rise      (rise_o[g]),
            .q_fall      (fall_o[g]),
            .conflict    (conf_o[g]),
            .conflict_cnt(w_cnt)
        );
        assign cnt_o[g] = 16'(w_cnt);
        assign obs[g]   = {q_o[g], rise_o[g], fall_o[g], conf_o[g], cnt_o[g]};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            mq[d]    = '0;
            mconf[d] = '0;
            mcnt[d]  = 0;
        end
    endtask

    // Drive one cycle of stimulus, predict every instance, wait for the next falling edge.
    task automatic step(input logic [3:0] ie, input logic [3:0] is, input logic [3:0] ir,
                        input logic iclr, input logic icclr);
        logic [3:0] nq;
        logic [3:0] evt;
        obs_t       e;
        en   = ie;
        s    = is;
        r    = ir;
        clr  = iclr;
        cclr = icclr;
        evt  = ie & is & ir;
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (iclr)                 nq[i] = 1'b0;
                else if (!ie[i])          nq[i] = mq[d][i];
                else if (is[i] && !ir[i]) nq[i] = 1'b1;
                else if (!is[i] && ir[i]) nq[i] = 1'b0;
                else if (is[i] && ir[i]) begin
                    if (d == 0)      nq[i] = mq[d][i];
                    else if (d == 1) nq[i] = 1'b1;
                    else if (d == 2) nq[i] = 1'b0;
                    else             nq[i] = ~mq[d][i];
                end else             nq[i] = mq[d][i];
            end
            mconf[d] = evt | (icclr ? 4'h0 : mconf[d]);
            if (icclr)                            mcnt[d] = (evt != 0) ? 1 : 0;
            else if (evt != 0 && mcnt[d] < cmax[d]) mcnt[d] = mcnt[d] + 1;
            e.q    = nq;
            e.rise = ~mq[d] & nq;
            e.fall = mq[d] & ~nq;
            e.conf = mconf[d];
            e.cnt  = 16'(mcnt[d]);
            expq[d].push_back(e);
            mq[d] = nq;
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        obs_t e;
        obs_t a;
        #1;
        for (int d = 0; d < 4; d++) begin
            if (expq[d].size() != 0) begin
                e = expq[d].pop_front();
                a = obs[d];
                vectors++;
                if (a !== e) begin
                    errs++;
                    $display("FAIL dut%0d: got q=%h rise=%h fall=%h conf=%h cnt=%0d expected q=%h rise=%h fall=%h conf=%h cnt=%0d",
                             d, a.q, a.rise, a.fall, a.conf, a.cnt, e.q, e.rise, e.fall, e.conf, e.cnt);
                end
            end
        end
    end

    initial begin
        logic exp_q0 [4];
        int   sat_exp;
        exp_q0 = '{1'b1, 1'b1, 1'b0, 1'b0};
        cmax   = '{255, 255, 255, 3};
        model_reset();

        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) chk($sformatf("reset_outputs%0d", d), obs[d], 32'h0);
        reset = 1'b1;

        step(4'hF, 4'b0101, 4'h0, 1'b0, 1'b0);
        chk("basic_set_q", 32'(q_o[0]), 32'h5);
        chk("basic_set_rise", 32'(rise_o[0]), 32'h5);
        step(4'hF, 4'h0, 4'b0001, 1'b0, 1'b0);
        chk("basic_rst_q", 32'(q_o[0]), 32'h4);
        chk("basic_rst_fall", 32'(fall_o[0]), 32'h1);

        step(4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        repeat (3) step(4'h1, 4'h1, 4'h1, 1'b0, 1'b0);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("mode%0d_q0", d), 32'(q_o[d][0]), 32'(exp_q0[d]));
            chk($sformatf("mode%0d_conflict0", d), 32'(conf_o[d][0]), 32'h1);
            chk($sformatf("mode%0d_cnt", d), 32'(cnt_o[d]), 32'd3);
        end
        chk("mode3_last_fall", 32'(fall_o[3][0]), 32'h1);

        step(4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        step(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        step(4'hF, 4'h1, 4'h1, 1'b1, 1'b0);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("clr_q%0d", d), 32'(q_o[d]), 32'h0);
            chk($sformatf("clr_fall%0d", d), 32'(fall_o[d]), 32'hF);
        end
        chk("clr_conflict0", 32'(conf_o[0][0]), 32'h1);
        chk("clr_cnt", 32'(cnt_o[0]), 32'd4);

        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(4'h1, 4'h1, 4'h1, 1'b0, 1'b0);
            sat_exp = (k + 1 > 3) ? 3 : k + 1;
            chk($sformatf("sat_cnt_%0d", k), 32'(cnt_o[3]), 32'(sat_exp));
        end
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("cclr_cnt", 32'(cnt_o[3]), 32'd0);
        chk("cclr_flags", 32'(conf_o[3]), 32'h0);
        step(4'h1, 4'h1, 4'h1, 1'b0, 1'b1);
        chk("cclr_evt_cnt", 32'(cnt_o[3]), 32'd1);
        chk("cclr_evt_flag", 32'(conf_o[3]), 32'h1);

        step(4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("multi_cnt", 32'(cnt_o[0]), 32'd2);
        chk("multi_flags", 32'(conf_o[0]), 32'hF);

        step(4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        repeat (5) step(4'h1, 4'h1, 4'h1, 1'b0, 1'b0);
        step(4'hF, 4'b1010, 4'b0101, 1'b0, 1'b0);
        chk("pre_reset_q", 32'(q_o[0]), 32'hA);
        chk("pre_reset_cnt", 32'(cnt_o[0]), 32'd5);
        en = '0; s = '0; r = '0; clr = 1'b0; cclr = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 4; d++) chk($sformatf("async_reset%0d", d), obs[d], 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("post_reset_fall", 32'(fall_o[0]), 32'h0);

        repeat (400) begin
            step(4'($urandom), 4'($urandom), 4'($urandom),
                 ($urandom % 16) == 0, ($urandom % 8) == 0);
        end

        @(posedge clk);
        #3;
        for (int d = 0; d < 4; d++) chk($sformatf("drain%0d", d), 32'(expq[d].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
